mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. It passes ALU results through for non-memory instructions. For loads and stores it runs a request/acknowledge transaction on the data bus, stalls the pipeline until the access completes, and aligns and extends load data. Word-sized, little-endian, single outstanding access.

## Interface
- `DATA_W`, 32: register/bus data width; fixed at 32 for byte-lane logic.
- `REG_ADDR_W`, 5: register-file address width.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `w_reg_addr_in` in REG_ADDR_W: destination register from EX/MEM.
- `w_reg_data_in` in DATA_W: ALU result from EX/MEM; for loads and stores this is also the effective address.
- `w_reg_en_in` in 1: write-back enable from EX/MEM.
- `mem_op` in 4: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none.
- `mem_wdata` in DATA_W: store data (rt value).
- `hold` in 1: downstream stall; MEM/WB will not capture this cycle.
- `dbus_req` out 1: bus request.
- `dbus_we` out 1: 1 = write.
- `dbus_addr` out 32: word address, `{w_reg_data_in[31:2],2'b00}`.
- `dbus_be` out 4: byte enables (bit i = bits 8i+7:8i).
- `dbus_wdata` out 32: lane-replicated store data.
- `dbus_ack` in 1: access complete; read data valid the same cycle.
- `dbus_rdata` in 32: read word.
- `w_reg_addr_out` out REG_ADDR_W: to MEM/WB.
- `w_reg_data_out` out DATA_W: to MEM/WB.
- `w_reg_en_out` out 1: to MEM/WB.
- `stall_req` out 1: freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- `addr_err` out 1: misaligned access (AdEL/AdES); 1 while the faulting instruction is in MEM.

## Operation
- Alignment rule: halfword ops need `addr[0]=0`; word ops need `addr[1:0]=0`. A misaligned op sets `addr_err=1`, `w_reg_en_out=0`, issues no bus request and no stall.
- Non-memory op: outputs equal inputs, `dbus_req=0`, `stall_req=0`.
- Stores: `w_reg_en_out=0` always.
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{d[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{d[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = d`.
- Loads: `dbus_be` is set as for the same-size store.
  - Selected lane = `rdata >> (8*addr[1:0])`, truncated to 8 or 16 bits.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the whole word.
  - `w_reg_data_out` is the extended value; `w_reg_en_out = w_reg_en_in`.
- FSM states:
  - IDLE: a valid aligned op asserts `dbus_req` in the same cycle (Mealy).
    - If `dbus_ack` also arrives and `hold=0`: complete and stay IDLE.
    - If `dbus_ack` arrives and `hold=1`: capture the extended load result in `ld_buf` and go to DONE.
    - If no `dbus_ack`: go to WAIT.
  - WAIT: `dbus_req=1`, and address, be, we and wdata stay stable.
    - On `dbus_ack`, go to IDLE if `hold=0`, otherwise capture `ld_buf` and go to DONE.
  - DONE: `dbus_req=0`; `w_reg_data_out=ld_buf`; `w_reg_en_out=w_reg_en_in`. Go to IDLE when `hold=0`. The held instruction is never re-issued.
- `stall_req` = (IDLE & valid aligned mem op & !dbus_ack) | (WAIT & !dbus_ack).
- While `stall_req=1`, `w_reg_en_out=0` (bubble).

## Timing
- Zero-wait bus (ack in request cycle): 0 stall cycles.
- N wait cycles: `stall_req` high for exactly N cycles; the result is valid on the ack cycle.
- `dbus_ack` is ignored when `dbus_req=0`.
- Reset (asynchronous, any state including WAIT and DONE):
  - FSM → IDLE, `ld_buf` → 0.
  - While `rst=1`: `dbus_req=0`, `stall_req=0`, `w_reg_en_out=0`, `addr_err=0`.
  - An abandoned bus transaction is the bus's responsibility.
- A new instruction may issue in the cycle after completion: IDLE → IDLE back-to-back, no dead cycle.
- `addr_err` and all outputs are combinational from inputs and state; there are no extra output registers.

## Test plan
- ALU pass-through: mem_op=0, addr=5, data=0x1234, en=1 → outputs identical same cycle; dbus_req=0, stall_req=0.
- LB with wait states: addr=0x103, rdata=0x80AA_BBCC, ack after 2 cycles → stall_req high 2 cycles; data_out=0xFFFF_FF80 on ack cycle; dbus_be=4'b1000.
- LHU zero-wait: addr=0x102, rdata=0x8001_0000, ack in same cycle → data_out=0x0000_8001, no stall.
- SH: addr=0x202, wdata=0x1234_ABCD → dbus_we=1, be=4'b1100, dbus_wdata=0xABCD_ABCD, w_reg_en_out=0.
- Hold at ack: LW, ack with rdata=0xDEAD_BEEF while hold=1 for 3 cycles → DONE, dbus_req=0 for those 3 cycles, data_out=0xDEAD_BEEF throughout, exactly one bus access.
- Misaligned and reset: LW at addr=0x6 → addr_err=1, no req, en_out=0. rst asserted mid-WAIT → dbus_req and stall_req drop immediately; state is IDLE after release.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: data-bus handshake, pipeline stall, load align/extend
module mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] w_reg_addr_in,
    input  logic [DATA_W-1:0]     w_reg_data_in,
    input  logic                  w_reg_en_in,
    input  logic [3:0]            mem_op,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  hold,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [31:0]           dbus_addr,
    output logic [3:0]            dbus_be,
    output logic [31:0]           dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [31:0]           dbus_rdata,
    output logic [REG_ADDR_W-1:0] w_reg_addr_out,
    output logic [DATA_W-1:0]     w_reg_data_out,
    output logic                  w_reg_en_out,
    output logic                  stall_req,
    output logic                  addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_ld_buf;

    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_byte;
    logic                w_is_half;
    logic                w_is_word;
    logic                w_misaligned;
    logic                w_valid;
    logic [1:0]          w_ofs;
    logic [31:0]         w_lane;
    logic [DATA_W-1:0]   w_ld_ext;
    logic                w_capture;

    assign w_ofs      = w_reg_data_in[1:0];
    assign w_is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    assign w_is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    assign w_is_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
    assign w_is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    assign w_is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);

    assign w_misaligned = (w_is_half && w_ofs[0]) || (w_is_word && (w_ofs != 2'b00));
    assign w_valid      = (w_is_load || w_is_store) && !w_misaligned;

    // Move the addressed byte/halfword down to bit 0, then extend by opcode
    assign w_lane = dbus_rdata >> {w_ofs, 3'b000};

    // Load result extension for the selected lane
    always_comb begin
        w_ld_ext = dbus_rdata;
        case (mem_op)
            OP_LB:   w_ld_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            OP_LBU:  w_ld_ext = {24'd0, w_lane[7:0]};
            OP_LH:   w_ld_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            OP_LHU:  w_ld_ext = {16'd0, w_lane[15:0]};
            default: w_ld_ext = dbus_rdata;
        endcase
    end

    // Bus address/lanes/data come straight from the frozen EX/MEM register, so they hold in WAIT
    always_comb begin
        dbus_addr  = {w_reg_data_in[31:2], 2'b00};
        dbus_we    = w_is_store;
        dbus_be    = 4'b0000;
        dbus_wdata = mem_wdata;
        if (w_is_byte) begin
            dbus_be    = 4'b0001 << w_ofs;
            dbus_wdata = {4{mem_wdata[7:0]}};
        end else if (w_is_half) begin
            dbus_be    = w_ofs[1] ? 4'b1100 : 4'b0011;
            dbus_wdata = {2{mem_wdata[15:0]}};
        end else if (w_is_word) begin
            dbus_be    = 4'b1111;
        end
    end

    // The load result must survive a downstream hold after the bus has already answered
    assign w_capture = dbus_ack && hold &&
                       (((r_state == ST_IDLE) && w_valid) || (r_state == ST_WAIT));

    // State register and held load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ld_buf <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_ld_buf <= w_ld_ext;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    if (!dbus_ack)    w_next_state = ST_WAIT;
                    else if (hold)    w_next_state = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (dbus_ack)         w_next_state = hold ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!hold)            w_next_state = ST_IDLE;
            end
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // Output logic; reset forces the handshake and write-back quiet immediately
    always_comb begin
        w_reg_addr_out = w_reg_addr_in;
        w_reg_data_out = w_reg_data_in;
        w_reg_en_out   = 1'b0;
        dbus_req       = 1'b0;
        stall_req      = 1'b0;
        addr_err       = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    addr_err = w_misaligned;
                    if (w_valid) begin
                        dbus_req  = 1'b1;
                        stall_req = !dbus_ack;
                        if (dbus_ack && w_is_load) begin
                            w_reg_data_out = w_ld_ext;
                            w_reg_en_out   = w_reg_en_in;
                        end
                    end else if (!w_misaligned) begin
                        w_reg_en_out = w_reg_en_in;
                    end
                end
                ST_WAIT: begin
                    dbus_req  = 1'b1;
                    stall_req = !dbus_ack;
                    if (dbus_ack && w_is_load) begin
                        w_reg_data_out = w_ld_ext;
                        w_reg_en_out   = w_reg_en_in;
                    end
                end
                ST_DONE: begin
                    w_reg_data_out = r_ld_buf;
                    w_reg_en_out   = w_reg_en_in && !w_is_store;
                end
                default: begin
                    w_reg_en_out = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  w_reg_addr_in;
    logic [31:0] w_reg_data_in;
    logic        w_reg_en_in;
    logic [3:0]  mem_op;
    logic [31:0] mem_wdata;
    logic        hold;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [4:0]  w_reg_addr_out;
    logic [31:0] w_reg_data_out;
    logic        w_reg_en_out;
    logic        stall_req;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int acc0;

    mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .w_reg_addr_in  (w_reg_addr_in),
        .w_reg_data_in  (w_reg_data_in),
        .w_reg_en_in    (w_reg_en_in),
        .mem_op         (mem_op),
        .mem_wdata      (mem_wdata),
        .hold           (hold),
        .dbus_req       (dbus_req),
        .dbus_we        (dbus_we),
        .dbus_addr      (dbus_addr),
        .dbus_be        (dbus_be),
        .dbus_wdata     (dbus_wdata),
        .dbus_ack       (dbus_ack),
        .dbus_rdata     (dbus_rdata),
        .w_reg_addr_out (w_reg_addr_out),
        .w_reg_data_out (w_reg_data_out),
        .w_reg_en_out   (w_reg_en_out),
        .stall_req      (stall_req),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && dbus_req && dbus_ack) n_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic ack, input logic [31:0] rd, input logic hd);
        mem_op        = op;
        w_reg_data_in = addr;
        mem_wdata     = wd;
        dbus_ack      = ack;
        dbus_rdata    = rd;
        hold          = hd;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        w_reg_addr_in = 5'd7;
        w_reg_en_in   = 1'b1;
        drive(4'd5, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_req",   {31'd0, dbus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_en",    {31'd0, w_reg_en_out}, 32'd0);
        drive(4'd5, 32'h6, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_aerr",  {31'd0, addr_err}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // ALU pass-through
        w_reg_addr_in = 5'd9;
        drive(4'd0, 32'h5, 32'h0, 1'b0, 32'h0, 1'b0);
        w_reg_data_in = 32'h1234; #1;
        chk("pt_data",  w_reg_data_out, 32'h1234);
        chk("pt_addr",  {27'd0, w_reg_addr_out}, 32'd9);
        chk("pt_en",    {31'd0, w_reg_en_out}, 32'd1);
        chk("pt_req",   {31'd0, dbus_req}, 32'd0);
        chk("pt_stall", {31'd0, stall_req}, 32'd0);
        drive(4'd12, 32'h3, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("op12_req", {31'd0, dbus_req}, 32'd0);
        chk("op12_en",  {31'd0, w_reg_en_out}, 32'd1);
        cyc();

        // LB with two wait cycles
        acc0 = n_acc;
        drive(4'd1, 32'h103, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("lb_req0",   {31'd0, dbus_req}, 32'd1);
        chk("lb_stall0", {31'd0, stall_req}, 32'd1);
        chk("lb_en0",    {31'd0, w_reg_en_out}, 32'd0);
        chk("lb_be",     {28'd0, dbus_be}, 32'b1000);
        chk("lb_addr",   dbus_addr, 32'h100);
        chk("lb_we",     {31'd0, dbus_we}, 32'd0);
        cyc();
        chk("lb_stall1", {31'd0, stall_req}, 32'd1);
        chk("lb_req1",   {31'd0, dbus_req}, 32'd1);
        cyc();
        drive(4'd1, 32'h103, 32'h0, 1'b1, 32'h80AABBCC, 1'b0);
        chk("lb_stall2", {31'd0, stall_req}, 32'd0);
        chk("lb_data",   w_reg_data_out, 32'hFFFFFF80);
        chk("lb_en2",    {31'd0, w_reg_en_out}, 32'd1);
        cyc();
        drive(4'd0, 32'h44, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("lb_idle_req", {31'd0, dbus_req}, 32'd0);
        chk("lb_accesses", n_acc - acc0, 32'd1);

        // LHU zero-wait, then LH/LBU/LW lanes
        drive(4'd4, 32'h102, 32'h0, 1'b1, 32'h80010000, 1'b0);
        chk("lhu_data",  w_reg_data_out, 32'h00008001);
        chk("lhu_stall", {31'd0, stall_req}, 32'd0);
        chk("lhu_be",    {28'd0, dbus_be}, 32'b1100);
        cyc();
        drive(4'd3, 32'h100, 32'h0, 1'b1, 32'h12348000, 1'b0);
        chk("lh_data",   w_reg_data_out, 32'hFFFF8000);
        cyc();
        drive(4'd2, 32'h101, 32'h0, 1'b1, 32'h0000F100, 1'b0);
        chk("lbu_data",  w_reg_data_out, 32'h000000F1);
        chk("lbu_be",    {28'd0, dbus_be}, 32'b0010);
        cyc();
        drive(4'd1, 32'h102, 32'h0, 1'b1, 32'h007F0000, 1'b0);
        chk("lb_pos",    w_reg_data_out, 32'h0000007F);
        cyc();
        drive(4'd5, 32'h104, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
        chk("lw_data",   w_reg_data_out, 32'hCAFEF00D);
        chk("lw_be",     {28'd0, dbus_be}, 32'b1111);
        cyc();

        // Stores
        drive(4'd7, 32'h202, 32'h1234ABCD, 1'b1, 32'h0, 1'b0);
        chk("sh_we",    {31'd0, dbus_we}, 32'd1);
        chk("sh_be",    {28'd0, dbus_be}, 32'b1100);
        chk("sh_wdata", dbus_wdata, 32'hABCDABCD);
        chk("sh_en",    {31'd0, w_reg_en_out}, 32'd0);
        cyc();
        drive(4'd6, 32'h201, 32'hAABBCC77, 1'b1, 32'h0, 1'b0);
        chk("sb_be",    {28'd0, dbus_be}, 32'b0010);
        chk("sb_wdata", dbus_wdata, 32'h77777777);
        cyc();
        drive(4'd8, 32'h204, 32'h89ABCDEF, 1'b1, 32'h0, 1'b0);
        chk("sw_wdata", dbus_wdata, 32'h89ABCDEF);
        chk("sw_en",    {31'd0, w_reg_en_out}, 32'd0);
        cyc();

        // Hold at ack: one access, result held in DONE
        acc0 = n_acc;
        drive(4'd5, 32'h300, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1);
        chk("hd_data0",  w_reg_data_out, 32'hDEADBEEF);
        chk("hd_stall0", {31'd0, stall_req}, 32'd0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(4'd5, 32'h300, 32'h0, 1'b1, 32'h11111111, 1'b1);
            chk("hd_req",   {31'd0, dbus_req}, 32'd0);
            chk("hd_data",  w_reg_data_out, 32'hDEADBEEF);
            chk("hd_stall", {31'd0, stall_req}, 32'd0);
            chk("hd_en",    {31'd0, w_reg_en_out}, 32'd1);
            cyc();
        end
        drive(4'd5, 32'h300, 32'h0, 1'b1, 32'h11111111, 1'b0);
        chk("hd_rel_req",  {31'd0, dbus_req}, 32'd0);
        chk("hd_rel_data", w_reg_data_out, 32'hDEADBEEF);
        cyc();
        chk("hd_accesses", n_acc - acc0, 32'd1);
        drive(4'd0, 32'h55, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("hd_after", w_reg_data_out, 32'h55);

        // Misaligned accesses
        drive(4'd5, 32'h6, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("mis_lw_err", {31'd0, addr_err}, 32'd1);
        chk("mis_lw_req", {31'd0, dbus_req}, 32'd0);
        chk("mis_lw_en",  {31'd0, w_reg_en_out}, 32'd0);
        chk("mis_lw_stl", {31'd0, stall_req}, 32'd0);
        drive(4'd7, 32'h201, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("mis_sh_err", {31'd0, addr_err}, 32'd1);
        drive(4'd3, 32'h202, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("al_lh_err",  {31'd0, addr_err}, 32'd0);
        cyc();

        // Reset in the middle of WAIT
        drive(4'd5, 32'h400, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("rw_stall", {31'd0, stall_req}, 32'd1);
        rst = 1'b1; #1;
        chk("rw_req",   {31'd0, dbus_req}, 32'd0);
        chk("rw_stl",   {31'd0, stall_req}, 32'd0);
        cyc();
        rst = 1'b0;
        drive(4'd0, 32'h66, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rw_idle_req", {31'd0, dbus_req}, 32'd0);
        chk("rw_idle_dat", w_reg_data_out, 32'h66);
        cyc();

        // Reset while in DONE
        drive(4'd5, 32'h500, 32'h0, 1'b1, 32'h5A5A5A5A, 1'b1);
        cyc();
        chk("rd_done", w_reg_data_out, 32'h5A5A5A5A);
        rst = 1'b1; #1;
        chk("rd_en", {31'd0, w_reg_en_out}, 32'd0);
        cyc();
        rst = 1'b0;
        drive(4'd0, 32'h77, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rd_idle_dat", w_reg_data_out, 32'h77);
        chk("rd_idle_en",  {31'd0, w_reg_en_out}, 32'd1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
